vecmac_dot_ctrl: RTL and testbench

Sequencer and accumulator around the 4-bit shift-add multiplier stage of the int8_vecmac datapath.
- Holds a small operand-pair buffer.
- Feeds each pair to the multiplier with its start/finish handshake.
- Consumes each 8-bit product and sums it into a dot-product result.
- Sits directly upstream of the multiplier (drives operands/start) and directly downstream of it (consumes out/finish).

---
 rtl/vecmac_pkg.sv | 34 +++
 rtl/vecmac_opbuf.sv | 45 ++++
 rtl/vecmac_dot_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_vecmac_dot_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vecmac_pkg.sv
// -----------------------------------------------------------------------------
// vecmac_pkg
// Shared definitions for the int8_vecmac dot-product sequencer:
//   - operand / product widths of the 4-bit shift-add multiplier stage
//   - controller state encoding
//   - operand-pair record stored in the operand buffer
//   - clog2 helper usable in parameter expressions
// -----------------------------------------------------------------------------
package vecmac_pkg;

   localparam int VM_OP_W  = 4;
   localparam int VM_MUL_W = 2 * VM_OP_W;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef struct packed {
      logic [VM_OP_W-1:0] a;
      logic [VM_OP_W-1:0] b;
   } opair_t;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/vecmac_opbuf.sv
// -----------------------------------------------------------------------------
// vecmac_opbuf
// N_ELEM-entry operand-pair register file for the dot-product sequencer.
// One registered write port, one combinational read port. All entries are
// cleared by the asynchronous reset.
//
// Ports:
//   clk_i      clock, posedge
//   rst_ni     asynchronous active-low reset (clears every entry)
//   wr_en_i    write strobe (gated by the caller)
//   wr_addr_i  write slot
//   wr_data_i  operand pair to store
//   rd_addr_i  read slot
//   rd_data_o  operand pair at rd_addr_i (combinational)
// -----------------------------------------------------------------------------
module vecmac_opbuf
   import vecmac_pkg::*;
#(
   parameter int N_ELEM = 8,
   parameter int AW     = clog2(N_ELEM)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  opair_t        wr_data_i,
   input  logic [AW-1:0] rd_addr_i,
   output opair_t        rd_data_o
);

   opair_t mem_q [N_ELEM];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < N_ELEM; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/vecmac_dot_ctrl.sv
// -----------------------------------------------------------------------------
// vecmac_dot_ctrl
// Sequencer + accumulator around the 4-bit shift-add multiplier stage.
// Holds a small operand-pair buffer, feeds each pair to the multiplier with
// the start/finish handshake and sums the 8-bit products into acc_out.
// With a 4-cycle multiplier each element takes 6 cycles (LOAD 1 + RUN 5).
//
// Ports:
//   clk         clock, posedge
//   rst         asynchronous active-low reset
//   wr_en       write operand pair into buffer (ignored while busy)
//   wr_addr     buffer slot
//   wr_a/wr_b   operands
//   len         element count 0..N_ELEM, sampled with go (larger values clamp)
//   go          start pulse (ignored while busy)
//   mul_a/mul_b registered operands to the multiplier
//   mul_start   0 = multiplier load/clear, 1 = multiplier run
//   mul_out     product from the multiplier
//   mul_finish  multiplier done level
//   acc_out     dot-product result, held until the next accepted go
//   done        one-cycle result-valid pulse
//   busy        high in every state except IDLE
//   err         sticky timeout flag, cleared by the next accepted go
// -----------------------------------------------------------------------------
module vecmac_dot_ctrl
   import vecmac_pkg::*;
#(
   parameter int N_ELEM   = 8,
   parameter int OP_W     = VM_OP_W,
   parameter int MUL_W    = VM_MUL_W,
   parameter int ACC_W    = 11,
   parameter int MAX_WAIT = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [clog2(N_ELEM)-1:0]  wr_addr,
   input  logic [OP_W-1:0]           wr_a,
   input  logic [OP_W-1:0]           wr_b,
   input  logic [clog2(N_ELEM):0]    len,
   input  logic                      go,
   output logic [OP_W-1:0]           mul_a,
   output logic [OP_W-1:0]           mul_b,
   output logic                      mul_start,
   input  logic [MUL_W-1:0]          mul_out,
   input  logic                      mul_finish,
   output logic [ACC_W-1:0]          acc_out,
   output logic                      done,
   output logic                      busy,
   output logic                      err
);

   localparam int AW = clog2(N_ELEM);
   localparam int LW = AW + 1;
   // Wait counter must be able to represent MAX_WAIT + 1 for the overflow test.
   localparam int WW = clog2(MAX_WAIT + 2);

   logic [1:0]       state_q, state_d;
   logic [AW-1:0]    idx_q,   idx_d;
   logic [LW-1:0]    len_q,   len_d;
   logic [WW-1:0]    wait_q,  wait_d;
   logic [ACC_W-1:0] acc_q,   acc_d;
   logic             err_q,   err_d;
   logic [OP_W-1:0]  mula_q,  mula_d;
   logic [OP_W-1:0]  mulb_q,  mulb_d;

   opair_t           wr_pair;
   opair_t           rd_pair;
   logic [LW-1:0]    len_clamped;
   logic [WW-1:0]    wait_inc;
   logic             wait_over;
   logic             last_elem;

   assign busy = (state_q != ST_IDLE);

   assign wr_pair = '{a: wr_a, b: wr_b};

   vecmac_opbuf #(
      .N_ELEM (N_ELEM),
      .AW     (AW)
   ) u_opbuf (
      .clk_i     (clk),
      .rst_ni    (rst),
      .wr_en_i   (wr_en & ~busy),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_pair),
      .rd_addr_i (idx_q),
      .rd_data_o (rd_pair)
   );

   assign len_clamped = (len > LW'(N_ELEM)) ? LW'(N_ELEM) : len;
   assign wait_inc    = wait_q + WW'(1);
   assign wait_over   = (wait_inc > WW'(MAX_WAIT));
   assign last_elem   = ({1'b0, idx_q} == (len_q - LW'(1)));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      wait_d  = wait_q;
      acc_d   = acc_q;
      err_d   = err_q;
      mula_d  = mula_q;
      mulb_d  = mulb_q;

      case (state_q)
         ST_IDLE: begin
            if (go) begin
               acc_d = '0;
               err_d = 1'b0;
               if (len_clamped == '0) begin
                  state_d = ST_DONE;
               end else begin
                  len_d   = len_clamped;
                  idx_d   = '0;
                  state_d = ST_LOAD;
               end
            end
         end

         // mul_finish may still be high from the previous element here, so it
         // is deliberately not looked at; mul_start=0 clears the multiplier.
         ST_LOAD: begin
            mula_d  = rd_pair.a;
            mulb_d  = rd_pair.b;
            wait_d  = '0;
            state_d = ST_RUN;
         end

         ST_RUN: begin
            if (mul_finish) begin
               acc_d = acc_q + ACC_W'(mul_out);
               if (last_elem) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + AW'(1);
                  state_d = ST_LOAD;
               end
            end else if (wait_over) begin
               // Abort without a done pulse; acc keeps the partial sum.
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               wait_d = wait_inc;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         wait_q  <= '0;
         acc_q   <= '0;
         err_q   <= 1'b0;
         mula_q  <= '0;
         mulb_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         wait_q  <= wait_d;
         acc_q   <= acc_d;
         err_q   <= err_d;
         mula_q  <= mula_d;
         mulb_q  <= mulb_d;
      end
   end

   assign mul_a     = mula_q;
   assign mul_b     = mulb_q;
   assign mul_start = (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);
   assign acc_out   = acc_q;
   assign err       = err_q;

endmodule

// File: tb/tb_vecmac_dot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vecmac_dot_ctrl
// Directed bench for vecmac_dot_ctrl with a behavioural 4-cycle multiplier
// attached. Expected results are queued when a go is issued and compared when
// the controller reports done (or err).
// -----------------------------------------------------------------------------
module tb_vecmac_dot_ctrl;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [3:0]  wr_a;
   logic [3:0]  wr_b;
   logic [3:0]  len;
   logic        go;
   logic [3:0]  mul_a;
   logic [3:0]  mul_b;
   logic        mul_start;
   logic [7:0]  mul_out;
   logic        mul_finish;
   logic [10:0] acc_out;
   logic        done;
   logic        busy;
   logic        err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int acc;
      int cyc;
      bit err;
      bit dn;
   } sb_item_t;

   sb_item_t sb_q[$];

   vecmac_dot_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_a       (wr_a),
      .wr_b       (wr_b),
      .len        (len),
      .go         (go),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_start  (mul_start),
      .mul_out    (mul_out),
      .mul_finish (mul_finish),
      .acc_out    (acc_out),
      .done       (done),
      .busy       (busy),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural multiplier: clears while mul_start=0, raises finish after
   // four run edges and holds it until mul_start drops. stub_hold freezes it.
   logic stub_hold;
   int   mcnt;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mcnt       <= 0;
         mul_finish <= 1'b0;
         mul_out    <= 8'd0;
      end else if (!mul_start) begin
         mcnt       <= 0;
         mul_finish <= 1'b0;
      end else if (!stub_hold && mcnt < 4) begin
         mcnt <= mcnt + 1;
         if (mcnt == 3) begin
            mul_finish <= 1'b1;
            mul_out    <= 8'(mul_a) * 8'(mul_b);
         end
      end
   end

   // Monitor: done pulses, mul_start rises, and low gaps between elements.
   int   done_cnt = 0;
   int   rise_cnt = 0;
   int   gap_bad  = 0;
   int   gap      = 0;
   logic ms_prev  = 1'b0;
   bit   in_gap   = 1'b0;

   always @(posedge clk) begin
      ms_prev <= mul_start;
      if (done === 1'b1) done_cnt <= done_cnt + 1;
      if (mul_start && !ms_prev) begin
         rise_cnt <= rise_cnt + 1;
         if (in_gap && gap != 1) gap_bad <= gap_bad + 1;
      end
      if (!mul_start && ms_prev && busy) begin
         in_gap <= 1'b1;
         gap    <= 1;
      end else if (!mul_start && in_gap) begin
         gap <= gap + 1;
      end
      if (!busy) in_gap <= 1'b0;
      if (mul_start && !ms_prev) in_gap <= 1'b0;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push(input int acc, input int cyc, input bit e, input bit dn);
      sb_item_t it;
      it.acc = acc;
      it.cyc = cyc;
      it.err = e;
      it.dn  = dn;
      sb_q.push_back(it);
   endtask

   task automatic write_slot(input int addr, input int a, input int b);
      wr_en   = 1'b1;
      wr_addr = 3'(addr);
      wr_a    = 4'(a);
      wr_b    = 4'(b);
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   // Returns at the negedge right after the go edge (cycle count 0).
   task automatic start_go(input int l);
      go  = 1'b1;
      len = 4'(l);
      @(negedge clk);
      go  = 1'b0;
      len = 4'd0;
   endtask

   task automatic wait_result(input string tag, input int n0);
      sb_item_t e;
      int n;
      int dbase;
      n     = n0;
      dbase = done_cnt;
      while (!(done === 1'b1 || err === 1'b1) && n < 120) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_sb_depth"}, sb_q.size(), 1);
      if (sb_q.size() == 0) return;
      e = sb_q.pop_front();
      chk({tag, "_cycles"}, n, e.cyc);
      chk({tag, "_done"}, done, e.dn);
      chk({tag, "_err"}, err, e.err);
      chk({tag, "_acc"}, acc_out, e.acc);
      @(negedge clk);
      chk({tag, "_busy_after"}, busy, 0);
      chk({tag, "_done_after"}, done, 0);
      chk({tag, "_done_pulses"}, done_cnt - dbase, e.dn);
   endtask

   initial begin
      int rb;
      int gb;
      rst       = 1'b1;
      go        = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = 3'd0;
      wr_a      = 4'd0;
      wr_b      = 4'd0;
      len       = 4'd0;
      stub_hold = 1'b0;
      #2 rst = 1'b0;
      @(negedge clk);

      // Reset state
      chk("rst_mul_a", mul_a, 0);
      chk("rst_mul_b", mul_b, 0);
      chk("rst_mul_start", mul_start, 0);
      chk("rst_acc", acc_out, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // 3*5 + 15*15 + 7*2 = 254
      write_slot(0, 3, 5);
      write_slot(1, 15, 15);
      write_slot(2, 7, 2);
      push(254, 18, 0, 1);
      start_go(3);
      wait_result("dot3", 0);

      // Empty vector
      rb = rise_cnt;
      push(0, 0, 0, 1);
      start_go(0);
      wait_result("len0", 0);
      chk("len0_no_start", rise_cnt - rb, 0);

      // Full-scale vector
      for (int i = 0; i < 8; i++) write_slot(i, 15, 15);
      rb = rise_cnt;
      gb = gap_bad;
      push(1800, 48, 0, 1);
      start_go(8);
      wait_result("full8", 0);
      chk("full8_start_rises", rise_cnt - rb, 8);
      chk("full8_gap_not_one", gap_bad - gb, 0);

      // len above N_ELEM clamps to N_ELEM
      push(1800, 48, 0, 1);
      start_go(15);
      wait_result("clamp15", 0);

      // Stuck multiplier: timeout after 16 RUN cycles
      stub_hold = 1'b1;
      push(0, 17, 1, 0);
      start_go(2);
      wait_result("timeout", 0);
      stub_hold = 1'b0;

      // Next go clears err
      push(675, 18, 0, 1);
      start_go(3);
      wait_result("err_cleared", 0);

      // go and wr_en while busy are ignored: 2*6 + 9*3 + 4*11 = 83
      write_slot(0, 2, 6);
      write_slot(1, 9, 3);
      write_slot(2, 4, 11);
      push(83, 18, 0, 1);
      start_go(3);
      @(negedge clk);
      @(negedge clk);
      go      = 1'b1;
      len     = 4'd2;
      wr_en   = 1'b1;
      wr_addr = 3'd1;
      wr_a    = 4'd15;
      wr_b    = 4'd15;
      @(negedge clk);
      go      = 1'b0;
      len     = 4'd0;
      wr_en   = 1'b0;
      wait_result("busy_ignore", 3);
      push(83, 18, 0, 1);
      start_go(3);
      wait_result("buf_unchanged", 0);

      // Write and go in the same cycle: write is visible to the run
      wr_en   = 1'b1;
      wr_addr = 3'd0;
      wr_a    = 4'd5;
      wr_b    = 4'd7;
      push(35, 6, 0, 1);
      start_go(1);
      wr_en   = 1'b0;
      wait_result("wr_with_go", 0);

      // Reset during the 2nd element of a len=4 run: 1*4+2*3+3*2+4*1 = 20
      write_slot(0, 1, 4);
      write_slot(1, 2, 3);
      write_slot(2, 3, 2);
      write_slot(3, 4, 1);
      start_go(4);
      repeat (8) @(negedge clk);
      chk("mid_partial_acc", acc_out, 4);
      chk("mid_busy", busy, 1);
      chk("mid_mul_a", mul_a, 2);
      rst = 1'b0;
      #1;
      chk("abort_mul_a", mul_a, 0);
      chk("abort_mul_b", mul_b, 0);
      chk("abort_mul_start", mul_start, 0);
      chk("abort_acc", acc_out, 0);
      chk("abort_done", done, 0);
      chk("abort_busy", busy, 0);
      chk("abort_err", err, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Buffer was cleared by reset
      push(0, 24, 0, 1);
      start_go(4);
      wait_result("cleared_buf", 0);

      write_slot(0, 1, 4);
      write_slot(1, 2, 3);
      write_slot(2, 3, 2);
      write_slot(3, 4, 1);
      push(20, 24, 0, 1);
      start_go(4);
      wait_result("rerun", 0);

      chk("sb_empty", sb_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
